// File: rtl/addsub_rr_scheduler_if.sv
// Bundle of request, shared-unit and response signals for addsub_rr_scheduler.
// Ports (by group):
//   req0_* / req1_* : job requests (valid/ready, operands a/b, op 0=add 1=sub)
//   au_*            : registered operands to the shared unit, its result/flags back
//   rsp_*           : tagged response channel (valid/ready, id, result, cout, v)
// The scheduler uses the slave modport; the environment uses master.
interface addsub_rr_scheduler_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;

    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic             au_op;
    logic [WIDTH-1:0] au_result;
    logic             au_cout;
    logic             au_v;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_v;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output au_a, au_b, au_op,
        input  au_result, au_cout, au_v,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_v,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  au_a, au_b, au_op,
        output au_result, au_cout, au_v,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_v,
        output rsp_ready
    );
endinterface

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one combinational add/sub unit between two
// requesters. One job in flight at a time: IDLE (grant) -> EXEC (unit
// evaluates registered operands) -> RESP (hold tagged result until taken).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : addsub_rr_scheduler_if.slave (requests, shared unit, response)
module addsub_rr_scheduler #(
    parameter int unsigned WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    addsub_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             grant;
    logic             take;
    logic             ready0;
    logic             ready1;

    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic             au_op;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_v;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req0_valid || bus.req1_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/ready: a lone requester wins; on contention the pointer decides
    always_comb begin
        grant  = 1'b0;
        take   = 1'b0;
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ptr;
        end else begin
            grant = bus.req1_valid;
        end
        if (state == IDLE) begin
            take   = bus.req0_valid || bus.req1_valid;
            ready0 = take && !grant;
            ready1 = take && grant;
        end
    end

    // Operand capture, result capture and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_a       <= '0;
            au_b       <= '0;
            au_op      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_v      <= 1'b0;
            ptr        <= 1'b0;
        end else begin
            if (take) begin
                au_a   <= grant ? bus.req1_a  : bus.req0_a;
                au_b   <= grant ? bus.req1_b  : bus.req0_b;
                au_op  <= grant ? bus.req1_op : bus.req0_op;
                rsp_id <= grant;
            end
            if (state == EXEC) begin
                rsp_result <= bus.au_result;
                rsp_cout   <= bus.au_cout;
                rsp_v      <= bus.au_v;
                rsp_valid  <= 1'b1;
            end
            // The requester just served loses priority to the other one
            if (state == RESP && bus.rsp_ready) begin
                rsp_valid <= 1'b0;
                ptr       <= ~rsp_id;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.au_a       = au_a;
    assign bus.au_b       = au_b;
    assign bus.au_op      = au_op;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_cout   = rsp_cout;
    assign bus.rsp_v      = rsp_v;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Self-checking bench for addsub_rr_scheduler: directed scenarios plus random
// traffic, checked every cycle against a job-level reference model.
module tb_addsub_rr_scheduler;

    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst_n;

    addsub_rr_scheduler_if #(.WIDTH(WIDTH)) bus ();

    addsub_rr_scheduler #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared add/sub unit: sub computed as A + ~B + 1
    logic [WIDTH-1:0] au_bx;
    logic [WIDTH:0]   au_sum;
    assign au_bx         = bus.au_op ? ~bus.au_b : bus.au_b;
    assign au_sum        = {1'b0, bus.au_a} + {1'b0, au_bx} + (WIDTH+1)'(bus.au_op);
    assign bus.au_result = au_sum[WIDTH-1:0];
    assign bus.au_cout   = au_sum[WIDTH];
    assign bus.au_v      = (bus.au_a[WIDTH-1] == au_bx[WIDTH-1]) &&
                           (au_sum[WIDTH-1] != bus.au_a[WIDTH-1]);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic from integer semantics: {v, cout, result}
    function automatic logic [WIDTH+1:0] ref_calc(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic op);
        int ua, ub, sa, sb, r, sr;
        logic cout, v;
        logic [WIDTH-1:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = a[WIDTH-1] ? ua - (1 << WIDTH) : ua;
        sb = b[WIDTH-1] ? ub - (1 << WIDTH) : ub;
        r    = op ? ua - ub : ua + ub;
        res  = WIDTH'(r);
        cout = op ? (ua >= ub) : (r >= (1 << WIDTH));
        sr   = op ? sa - sb : sa + sb;
        v    = (sr > (1 << (WIDTH-1)) - 1) || (sr < -(1 << (WIDTH-1)));
        return {v, cout, res};
    endfunction

    // Requester intent (held until accepted)
    logic             pv  [2];
    logic [WIDTH-1:0] pa  [2];
    logic [WIDTH-1:0] pb  [2];
    logic             pop [2];
    logic             rr;

    // Job-level model: at most one job outstanding
    bit               busy;
    int               hs_cyc;
    logic             job_id;
    logic [WIDTH-1:0] job_a, job_b;
    logic             job_op;
    logic             last_id;
    int               cyc;

    // Observation logs for directed checks
    int               hs_ids[$];
    int               hs_cycs[$];
    int               cons_cyc;
    int               rv_cycles;
    logic [WIDTH-1:0] cap_result;
    logic             cap_cout, cap_v, cap_id;

    task automatic model_reset();
        busy    = 1'b0;
        last_id = 1'b1;
    endtask

    task automatic drive_inputs();
        bus.req0_valid = pv[0];
        bus.req0_a     = pa[0];
        bus.req0_b     = pb[0];
        bus.req0_op    = pop[0];
        bus.req1_valid = pv[1];
        bus.req1_a     = pa[1];
        bus.req1_b     = pb[1];
        bus.req1_op    = pop[1];
        bus.rsp_ready  = rr;
    endtask

    // One clock: drive, check against model, advance model, then to next negedge
    task automatic step();
        logic e0, e1, erv;
        logic [WIDTH+1:0] exp;
        drive_inputs();
        #1;
        e0  = !busy && pv[0] && (!pv[1] || last_id == 1'b1);
        e1  = !busy && pv[1] && (!pv[0] || last_id == 1'b0);
        erv = busy && (cyc >= hs_cyc + 2);
        check_eq("req0_ready", 32'(bus.req0_ready), 32'(e0));
        check_eq("req1_ready", 32'(bus.req1_ready), 32'(e1));
        check_eq("rsp_valid",  32'(bus.rsp_valid),  32'(erv));
        if (busy) begin
            check_eq("au_a",  32'(bus.au_a),  32'(job_a));
            check_eq("au_b",  32'(bus.au_b),  32'(job_b));
            check_eq("au_op", 32'(bus.au_op), 32'(job_op));
        end
        if (erv && bus.rsp_valid) begin
            exp = ref_calc(job_a, job_b, job_op);
            check_eq("rsp_id",     32'(bus.rsp_id),     32'(job_id));
            check_eq("rsp_result", 32'(bus.rsp_result), 32'(exp[WIDTH-1:0]));
            check_eq("rsp_cout",   32'(bus.rsp_cout),   32'(exp[WIDTH]));
            check_eq("rsp_v",      32'(bus.rsp_v),      32'(exp[WIDTH+1]));
            cap_result = bus.rsp_result;
            cap_cout   = bus.rsp_cout;
            cap_v      = bus.rsp_v;
            cap_id     = bus.rsp_id;
            rv_cycles++;
        end
        if (e0 || e1) begin
            job_id = e1;
            job_a  = e1 ? pa[1]  : pa[0];
            job_b  = e1 ? pb[1]  : pb[0];
            job_op = e1 ? pop[1] : pop[0];
            busy   = 1'b1;
            hs_cyc = cyc;
            hs_ids.push_back(int'(e1));
            hs_cycs.push_back(cyc);
        end else if (erv && rr) begin
            busy     = 1'b0;
            last_id  = job_id;
            cons_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        if (e0) pv[0] = 1'b0;
        if (e1) pv[1] = 1'b0;
        @(negedge clk);
    endtask

    // Async reset applied mid-cycle; all registered outputs must clear at once
    task automatic do_reset(input string tag);
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        drive_inputs();
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        check_eq({tag, "_rsp_id"},     32'(bus.rsp_id),     32'd0);
        check_eq({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        check_eq({tag, "_rsp_flags"},  32'({bus.rsp_cout, bus.rsp_v}), 32'd0);
        check_eq({tag, "_au"},         32'({bus.au_a, bus.au_b, bus.au_op}), 32'd0);
        check_eq({tag, "_ready"},      32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_job(input int n, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic op);
        pv[n]  = 1'b1;
        pa[n]  = a;
        pb[n]  = b;
        pop[n] = op;
    endtask

    initial begin
        rst_n  = 1'b0;
        pv[0]  = 1'b0; pv[1] = 1'b0;
        pa[0]  = '0;   pa[1] = '0;
        pb[0]  = '0;   pb[1] = '0;
        pop[0] = 1'b0; pop[1] = 1'b0;
        rr     = 1'b1;
        cyc    = 0;
        hs_cyc = 0;
        job_id = 1'b0; job_a = '0; job_b = '0; job_op = 1'b0;
        cons_cyc = 0; rv_cycles = 0;
        cap_result = '0; cap_cout = 1'b0; cap_v = 1'b0; cap_id = 1'b0;
        model_reset();
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        do_reset("reset");

        // req0 alone: 0110 + 0101
        set_job(0, 4'b0110, 4'b0101, 1'b0);
        rr = 1'b1;
        rv_cycles = 0;
        repeat (5) step();
        check_eq("a_rsp_id",     32'(cap_id),     32'd0);
        check_eq("a_rsp_result", 32'(cap_result), 32'b1011);
        check_eq("a_rsp_cout",   32'(cap_cout),   32'd0);
        check_eq("a_rsp_v",      32'(cap_v),      32'd1);
        check_eq("a_rsp_cycles", 32'(rv_cycles),  32'd1);

        // req1 alone: 1010 - 1110, response stalled; req0 shows up during the stall
        set_job(1, 4'b1010, 4'b1110, 1'b1);
        rr = 1'b0;
        rv_cycles = 0;
        hs_ids.delete();
        hs_cycs.delete();
        step();
        step();
        step();
        set_job(0, 4'b0011, 4'b0100, 1'b1);
        step();
        step();
        rr = 1'b1;
        step();
        step();
        check_eq("b_rsp_id",     32'(cap_id),     32'd1);
        check_eq("b_rsp_result", 32'(cap_result), 32'b1100);
        check_eq("b_rsp_cout",   32'(cap_cout),   32'd0);
        check_eq("b_rsp_v",      32'(cap_v),      32'd0);
        check_eq("b_stall_len",  32'(rv_cycles),  32'd4);
        check_eq("b_next_grant", 32'(hs_ids[hs_ids.size()-1]), 32'd0);
        check_eq("b_next_cyc",   32'(hs_cycs[hs_cycs.size()-1]), 32'(cons_cyc + 1));
        repeat (3) step();

        // Both valid from reset, rsp_ready tied high: alternation and 3-cycle issue
        do_reset("c_reset");
        hs_ids.delete();
        hs_cycs.delete();
        rr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!pv[0]) set_job(0, 4'b1111, 4'b0000, 1'b0);
            if (!pv[1]) set_job(1, 4'b1001, 4'b0110, 1'b1);
            step();
        end
        check_eq("c_hs_count", 32'(hs_ids.size()), 32'd4);
        for (int i = 0; i < hs_ids.size(); i++) begin
            check_eq("c_grant_order", 32'(hs_ids[i]), 32'(i % 2));
            if (i > 0) check_eq("c_issue_gap", 32'(hs_cycs[i] - hs_cycs[i-1]), 32'd3);
        end

        // Reset while a response is pending, then both valid: req0 first
        do_reset("d_pre");
        set_job(1, 4'b0111, 4'b0001, 1'b0);
        rr = 1'b0;
        rv_cycles = 0;
        repeat (4) step();
        check_eq("d_pending", 32'(rv_cycles), 32'd2);
        do_reset("d_mid_resp");
        hs_ids.delete();
        set_job(0, 4'b0001, 4'b0010, 1'b0);
        set_job(1, 4'b0100, 4'b0101, 1'b1);
        rr = 1'b1;
        step();
        check_eq("d_first_grant", 32'(hs_ids.size() > 0 ? hs_ids[0] : 9), 32'd0);
        repeat (6) step();

        // Random traffic with random response back-pressure
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && $urandom_range(0, 2) == 0)
                    set_job(n, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            end
            rr = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
